// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754-style adder/subtractor: one operation in flight, fixed
// 5-cycle start-to-done latency, round-to-nearest-even, denormals flushed to zero.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;
  localparam int XW  = EXP_W + 2;
  localparam int SHW = $clog2(MW);
  localparam logic [EXP_W-1:0]     EONES = '1;
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;
  localparam logic signed [XW-1:0] EONE  = XW'(1);
  localparam logic [W-1:0]         QNAN  = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;
  state_t state_q, state_d;

  logic               sa_d, sb_d, sa_q, sb_q, swap;
  logic [EXP_W-1:0]   ea_d, eb_d, ea_q, eb_q;
  logic [MAN_W-1:0]   fa_d, fb_d, fa_q, fb_q;
  logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic               spec_d, spec_q;
  logic [W-1:0]       spec_res_d, spec_res_q;
  logic [3:0]         spec_flg_d, spec_flg_q;
  logic [EXP_W-1:0]   diff;
  logic [SHW-1:0]     shamt;
  logic [MW-1:0]      mb_ext, mb_sh, mask, ma_d, mb_d, ma_q, mb_q;
  logic [MW:0]        sum_d, sum_q;
  logic [SHW-1:0]     lz;
  logic signed [XW-1:0] exa, en_d, en_q;
  logic [MW-1:0]      mn_d, mn_q;
  logic               zero_d, zero_q;
  logic [W+3:0]       rf_d;
  logic [W-1:0]       result_q;
  logic [3:0]         flags_q;

  function automatic logic [SHW-1:0] lzc_f(input logic [MW-1:0] v);
    lzc_f = '0;
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc_f = SHW'(MW - 1 - i);
  endfunction

  // Returns {result, flags}; m is normalised {hidden, frac, G, R, S}.
  function automatic logic [W+3:0] pack_f(input logic s, input logic signed [XW-1:0] e,
                                          input logic [MW-1:0] m, input logic z);
    logic [MAN_W+1:0]     rnd;
    logic                 g, r, st, inc;
    logic signed [XW-1:0] er;
    logic [MAN_W-1:0]     fr;
    g   = m[2];
    r   = m[1];
    st  = m[0];
    inc = g & (r | st | m[3]);
    rnd = {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er  = rnd[MAN_W+1] ? e + EONE : e;
    fr  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    if (z)                pack_f = '0;
    else if (er >= EMAX)  pack_f = {s, EONES, {MAN_W{1'b0}}, 4'b0101};
    else if (er <= EZERO) pack_f = {s, {(W-1){1'b0}}, 4'b0011};
    else                  pack_f = {s, er[EXP_W-1:0], fr, 3'b000, g | r | st};
  endfunction

  // Capture: effective sign of op2, swap so A has the larger magnitude
  assign swap = op2[W-2:0] > op1[W-2:0];
  assign sa_d = swap ? (op2[W-1] ^ sub) : op1[W-1];
  assign sb_d = swap ? op1[W-1] : (op2[W-1] ^ sub);
  assign ea_d = swap ? op2[W-2:MAN_W] : op1[W-2:MAN_W];
  assign eb_d = swap ? op1[W-2:MAN_W] : op2[W-2:MAN_W];
  assign fa_d = swap ? op2[MAN_W-1:0] : op1[MAN_W-1:0];
  assign fb_d = swap ? op1[MAN_W-1:0] : op2[MAN_W-1:0];
  assign zero_a = (ea_d == '0);
  assign zero_b = (eb_d == '0);
  assign inf_a  = (ea_d == EONES) && (fa_d == '0);
  assign inf_b  = (eb_d == EONES) && (fb_d == '0);
  assign nan_a  = (ea_d == EONES) && (fa_d != '0);
  assign nan_b  = (eb_d == EONES) && (fb_d != '0);

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = QNAN;
    spec_flg_d = 4'b0000;
    if (nan_a || nan_b)                       spec_flg_d = 4'b0000;
    else if (inf_a && inf_b && (sa_d != sb_d)) spec_flg_d = 4'b1000;
    else if (inf_a)  spec_res_d = {sa_d, EONES, {MAN_W{1'b0}}};
    else if (zero_a) spec_res_d = {sa_d & sb_d, {(W-1){1'b0}}};
    else if (zero_b) spec_res_d = {sa_d, ea_d, fa_d};
    else             spec_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      sa_q <= sa_d;  sb_q <= sb_d;
      ea_q <= ea_d;  eb_q <= eb_d;
      fa_q <= fa_d;  fb_q <= fb_d;
      spec_q <= spec_d;  spec_res_q <= spec_res_d;  spec_flg_q <= spec_flg_d;
    end
  end

  // Align: B shifted right, shift saturates, lost bits collapse into sticky
  assign diff   = ea_q - eb_q;
  assign shamt  = (32'(diff) > 32'(MW - 1)) ? SHW'(MW - 1) : SHW'(diff);
  assign mb_ext = {1'b1, fb_q, 3'b000};
  assign mask   = ~({MW{1'b1}} << shamt);
  assign mb_sh  = mb_ext >> shamt;
  assign ma_d   = {1'b1, fa_q, 3'b000};
  assign mb_d   = {mb_sh[MW-1:1], mb_sh[0] | (|(mb_ext & mask))};

  // Add: after the swap the difference can never go negative
  assign sum_d = (sa_q ^ sb_q) ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

  // Normalise
  assign lz  = lzc_f(sum_q[MW-1:0]);
  assign exa = $signed({2'b00, ea_q});
  always_comb begin
    mn_d   = sum_q[MW-1:0] << lz;
    en_d   = exa - $signed(XW'(lz));
    zero_d = (sum_q == '0);
    if (sum_q[MW]) begin
      mn_d   = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      en_d   = exa + EONE;
      zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ALIGN) begin
      ma_q <= ma_d;
      mb_q <= mb_d;
    end
    if (state_q == ADD) sum_q <= sum_d;
    if (state_q == NORM) begin
      mn_q   <= mn_d;
      en_q   <= en_d;
      zero_q <= zero_d;
    end
  end

  // Round and pack; special operands override the datapath
  assign rf_d = spec_q ? {spec_res_q, spec_flg_q} : pack_f(sa_q, en_q, mn_q, zero_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == ROUND) begin
      {result_q, flags_q} <= rf_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? ALIGN : IDLE;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ALIGN) || (state_q == ADD) || (state_q == NORM) || (state_q == ROUND);
    done = (state_q == OUT);
  end

endmodule
